// File: rtl/uart_rx_param_top_if.sv
// Host-side read port of the UART receiver: FIFO pop, overrun clear, head word and status.
interface uart_rx_param_top_if #(
  parameter int DATA_BITS = 8,
  parameter int FIFO_EXP  = 4
);
  logic                 read_uart;
  logic                 clr_overrun;
  logic [DATA_BITS-1:0] read_data;
  logic                 read_parity_err;
  logic                 read_frame_err;
  logic                 rx_full;
  logic                 rx_empty;
  logic [FIFO_EXP:0]    rx_level;
  logic                 overrun;

  modport master (
    output read_uart, clr_overrun,
    input  read_data, read_parity_err, read_frame_err, rx_full, rx_empty, rx_level, overrun
  );

  modport slave (
    input  read_uart, clr_overrun,
    output read_data, read_parity_err, read_frame_err, rx_full, rx_empty, rx_level, overrun
  );
endinterface

// File: rtl/uart_rx_param_top.sv
// UART receiver: baud tick, 2-FF synchroniser, 16x oversampling FSM, fall-through FIFO
// whose entries carry {frame_err, parity_err, data}.
module uart_rx_param_top #(
  parameter int DATA_BITS     = 8,
  parameter int PARITY_MODE   = 0,
  parameter int STOP_BIT_TICK = 16,
  parameter int BR_LIMIT      = 326,
  parameter int BR_BITS       = 9,
  parameter int FIFO_EXP      = 4
) (
  input logic                clk_50MHz,
  input logic                reset,
  input logic                rx,
  uart_rx_param_top_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_EXP;
  localparam int SW    = (STOP_BIT_TICK > 16) ? 5 : 4;
  localparam int NW    = $clog2(DATA_BITS);
  localparam int EW    = DATA_BITS + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Input synchroniser, idle-high so reset never looks like a start bit.
  logic rx_meta_reg, rx_s_reg;
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  logic [BR_BITS-1:0] br_cnt_reg;
  logic               tick;
  assign tick = (br_cnt_reg == BR_BITS'(BR_LIMIT - 1));

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) br_cnt_reg <= '0;
    else       br_cnt_reg <= tick ? '0 : br_cnt_reg + BR_BITS'(1);
  end

  state_t               state_reg;
  logic [SW-1:0]        s_cnt_reg;
  logic [NW-1:0]        n_reg;
  logic [DATA_BITS-1:0] b_reg;
  logic                 perr_reg, ferr_reg, rx_done_reg;

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      s_cnt_reg   <= '0;
      n_reg       <= '0;
      b_reg       <= '0;
      perr_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
      rx_done_reg <= 1'b0;
    end else begin
      rx_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!rx_s_reg) begin
            state_reg <= START;
            s_cnt_reg <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (s_cnt_reg == SW'(7)) begin
              // Mid-start-bit recheck rejects short glitches on the line.
              if (!rx_s_reg) begin
                state_reg <= DATA;
                s_cnt_reg <= '0;
                n_reg     <= '0;
                perr_reg  <= 1'b0;
                ferr_reg  <= 1'b0;
              end else begin
                state_reg <= IDLE;
              end
            end else begin
              s_cnt_reg <= s_cnt_reg + SW'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s_cnt_reg == SW'(15)) begin
              s_cnt_reg <= '0;
              b_reg     <= {rx_s_reg, b_reg[DATA_BITS-1:1]};
              if (n_reg == NW'(DATA_BITS - 1))
                state_reg <= (PARITY_MODE != 0) ? PARITY : STOP;
              else
                n_reg <= n_reg + NW'(1);
            end else begin
              s_cnt_reg <= s_cnt_reg + SW'(1);
            end
          end
        end
        PARITY: begin
          if (tick) begin
            if (s_cnt_reg == SW'(15)) begin
              perr_reg  <= ((^b_reg) ^ rx_s_reg) != (PARITY_MODE == 2);
              state_reg <= STOP;
              s_cnt_reg <= '0;
            end else begin
              s_cnt_reg <= s_cnt_reg + SW'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            // Only the first stop bit is checked; extra stop time is just waited out.
            if (s_cnt_reg == SW'(15))
              ferr_reg <= ~rx_s_reg;
            if (s_cnt_reg == SW'(STOP_BIT_TICK - 1)) begin
              state_reg   <= IDLE;
              rx_done_reg <= 1'b1;
            end else begin
              s_cnt_reg <= s_cnt_reg + SW'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic [EW-1:0]       mem [DEPTH];
  logic [FIFO_EXP-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_EXP:0]   level_reg;
  logic                overrun_reg;
  logic                full, empty, do_push, do_pop;
  logic [EW-1:0]       head;

  assign full    = (level_reg == (FIFO_EXP + 1)'(DEPTH));
  assign empty   = (level_reg == '0);
  assign do_pop  = bus.read_uart && !empty;
  // A full FIFO still accepts the word when a pop frees the slot in the same cycle.
  assign do_push = rx_done_reg && (!full || do_pop);

  always_ff @(posedge clk_50MHz) begin
    if (do_push) mem[wr_ptr_reg] <= {ferr_reg, perr_reg, b_reg};
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + FIFO_EXP'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + FIFO_EXP'(1);
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + (FIFO_EXP + 1)'(1);
        2'b01:   level_reg <= level_reg - (FIFO_EXP + 1)'(1);
        default: level_reg <= level_reg;
      endcase
      if (rx_done_reg && !do_push) overrun_reg <= 1'b1;
      else if (bus.clr_overrun)    overrun_reg <= 1'b0;
    end
  end

  assign head                = mem[rd_ptr_reg];
  assign bus.read_data       = empty ? '0 : head[DATA_BITS-1:0];
  assign bus.read_parity_err = !empty && (PARITY_MODE != 0) && head[DATA_BITS];
  assign bus.read_frame_err  = !empty && head[DATA_BITS+1];
  assign bus.rx_full         = full;
  assign bus.rx_empty        = empty;
  assign bus.rx_level        = level_reg;
  assign bus.overrun         = overrun_reg;
endmodule

// File: tb/tb_uart_rx_param_top.sv
// Four receivers (8N1, 8E1, 8O1, 7N2) on a fast baud divider; a scoreboard queue holds the
// expected head words and a negedge monitor checks every pop against it.
module tb_uart_rx_param_top;
  localparam int BRL = 4;
  localparam int BIT = 16 * BRL;
  localparam int FE  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_line [4];
  logic       rd      [4];
  logic       clr     [4];
  logic [7:0] data_a  [4];
  logic       perr_a  [4];
  logic       ferr_a  [4];
  logic       full_a  [4];
  logic       empty_a [4];
  logic       ovr_a   [4];
  logic [2:0] lvl_a   [4];

  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] exp_q [$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int DB = (gi == 3) ? 7 : 8;
    localparam int PM = (gi == 1) ? 1 : ((gi == 2) ? 2 : 0);
    localparam int ST = (gi == 3) ? 32 : 16;
    uart_rx_param_top_if #(.DATA_BITS(DB), .FIFO_EXP(FE)) bus ();
    assign bus.read_uart   = rd[gi];
    assign bus.clr_overrun = clr[gi];
    assign data_a[gi]      = 8'(bus.read_data);
    assign perr_a[gi]      = bus.read_parity_err;
    assign ferr_a[gi]      = bus.read_frame_err;
    assign full_a[gi]      = bus.rx_full;
    assign empty_a[gi]     = bus.rx_empty;
    assign ovr_a[gi]       = bus.overrun;
    assign lvl_a[gi]       = bus.rx_level;
    uart_rx_param_top #(
      .DATA_BITS(DB), .PARITY_MODE(PM), .STOP_BIT_TICK(ST),
      .BR_LIMIT(BRL), .BR_BITS(3), .FIFO_EXP(FE)
    ) dut (
      .clk_50MHz(clk), .reset(rst), .rx(rx_line[gi]), .bus(bus.slave)
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  function automatic logic [11:0] mk(input int idx, input logic f, input logic p, input logic [7:0] d);
    return {idx[1:0], f, p, d};
  endfunction

  // {empty, full, level[2:0], overrun}
  function automatic logic [31:0] stat(input int i);
    return 32'({empty_a[i], full_a[i], lvl_a[i], ovr_a[i]});
  endfunction

  function automatic logic [31:0] all_out(input int i);
    return 32'({empty_a[i], full_a[i], lvl_a[i], ovr_a[i], data_a[i], perr_a[i], ferr_a[i]});
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // par < 0: no parity bit; stop_lo > 0 holds the stop bit low for that many clocks first.
  task automatic send(input int idx, input logic [7:0] d, input int nbits, input int par,
                      input int stop_lo, input int stop_hi);
    rx_line[idx] = 1'b0;
    step(BIT);
    for (int b = 0; b < nbits; b++) begin
      rx_line[idx] = d[b];
      step(BIT);
    end
    if (par >= 0) begin
      rx_line[idx] = par[0];
      step(BIT);
    end
    if (stop_lo > 0) begin
      rx_line[idx] = 1'b0;
      step(stop_lo);
    end
    rx_line[idx] = 1'b1;
    step(stop_hi);
  endtask

  task automatic pop(input int idx);
    rd[idx] = 1'b1;
    step(1);
    rd[idx] = 1'b0;
    step(1);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst && rd[i] && !empty_a[i]) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL pop_unexpected: dut %0d presented 0x%0h, expected no word", i, data_a[i]);
        end else begin
          chk($sformatf("pop_dut%0d", i), 32'({2'(i), ferr_a[i], perr_a[i], data_a[i]}),
              32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_line[i] = 1'b1;
      rd[i]      = 1'b0;
      clr[i]     = 1'b0;
    end
    step(5);
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("reset_dut%0d", i), all_out(i), 32'h8000);
    step(1);
    rst = 1'b0;
    step(10);

    // Three 8N1 words, no reads, then drain.
    send(0, 8'h41, 8, -1, 0, 2 * BIT); exp_q.push_back(mk(0, 1'b0, 1'b0, 8'h41));
    send(0, 8'h42, 8, -1, 0, 2 * BIT); exp_q.push_back(mk(0, 1'b0, 1'b0, 8'h42));
    send(0, 8'h43, 8, -1, 0, 2 * BIT); exp_q.push_back(mk(0, 1'b0, 1'b0, 8'h43));
    @(negedge clk);
    chk("level3", stat(0), 'b000110);
    step(1);
    for (int k = 0; k < 3; k++) pop(0);
    @(negedge clk);
    chk("drained_8n1", 32'(exp_q.size()), 0);
    chk("empty_after_pops", all_out(0), 32'h8000);
    step(1);

    // Framing error: stop bit low through its sampling point, then idle.
    send(0, 8'h55, 8, -1, 48, 2 * BIT); exp_q.push_back(mk(0, 1'b1, 1'b0, 8'h55));
    @(negedge clk);
    chk("frame_level1", stat(0), 'b000010);
    step(1);
    pop(0);

    // Overrun: depth 4, five words; the fifth is dropped.
    for (int k = 1; k <= 5; k++) begin
      send(0, 8'(k), 8, -1, 0, BIT);
      if (k <= 4) exp_q.push_back(mk(0, 1'b0, 1'b0, 8'(k)));
    end
    step(BIT);
    @(negedge clk);
    chk("full_overrun", stat(0), 'b011001);
    step(1);
    for (int k = 0; k < 4; k++) pop(0);
    @(negedge clk);
    chk("drained_overrun", 32'(exp_q.size()), 0);
    chk("overrun_sticky", stat(0), 'b100001);
    step(1);
    clr[0] = 1'b1;
    step(1);
    clr[0] = 1'b0;
    @(negedge clk);
    chk("overrun_cleared", stat(0), 'b100000);
    step(1);

    // Glitch shorter than half a bit: no word.
    rx_line[0] = 1'b0;
    step(12);
    rx_line[0] = 1'b1;
    step(12 * BIT);
    @(negedge clk);
    chk("glitch_no_word", all_out(0), 32'h8000);
    step(1);

    // Even parity (dut1) and odd parity (dut2): 0x41 has even weight.
    send(1, 8'h41, 8, 0, 0, 2 * BIT); exp_q.push_back(mk(1, 1'b0, 1'b0, 8'h41));
    send(1, 8'h41, 8, 1, 0, 2 * BIT); exp_q.push_back(mk(1, 1'b0, 1'b1, 8'h41));
    @(negedge clk);
    chk("even_level2", stat(1), 'b000100);
    step(1);
    pop(1);
    pop(1);
    send(2, 8'h41, 8, 0, 0, 2 * BIT); exp_q.push_back(mk(2, 1'b0, 1'b1, 8'h41));
    send(2, 8'h41, 8, 1, 0, 2 * BIT); exp_q.push_back(mk(2, 1'b0, 1'b0, 8'h41));
    pop(2);
    pop(2);
    @(negedge clk);
    chk("drained_parity", 32'(exp_q.size()), 0);
    step(1);

    // 7 data bits, 2 stop bits: word lands 8+112+32 ticks after the start edge, +sync/FIFO.
    cnt = 0;
    fork
      send(3, 8'h5A, 7, -1, 0, 3 * BIT);
      begin
        while (empty_a[3] && cnt < 1000) begin
          @(negedge clk);
          cnt++;
        end
      end
    join
    exp_q.push_back(mk(3, 1'b0, 1'b0, 8'h5A));
    n_cmp++;
    if (cnt < 600 || cnt > 624) begin
      n_bad++;
      $display("FAIL latency_7n2: got %0d cycles, expected 600..624", cnt);
    end
    pop(3);
    @(negedge clk);
    chk("drained_7n2", 32'(exp_q.size()), 0);
    step(1);

    // Reset in the middle of a frame with a word already queued.
    send(0, 8'hA5, 8, -1, 0, 2 * BIT);
    rx_line[0] = 1'b0;
    step(BIT);
    rx_line[0] = 1'b1;
    step(BIT);
    rx_line[0] = 1'b0;
    step(BIT / 2);
    @(negedge clk);
    chk("pre_reset_level1", stat(0), 'b000010);
    step(1);
    rst = 1'b1;
    rx_line[0] = 1'b1;
    step(4);
    @(negedge clk);
    chk("mid_frame_reset", all_out(0), 32'h8000);
    step(1);
    rst = 1'b0;
    step(12 * BIT);
    @(negedge clk);
    chk("no_word_after_reset", all_out(0), 32'h8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_param_top.md
# uart_rx_param_top

Parametrised UART receive subsystem: baud-tick generator, 2-FF input synchroniser, 16x-oversampling receiver FSM with configurable data width, parity mode and stop length, and a first-word-fall-through receive FIFO that stores per-word error flags. It sits between the board `rx` pin and the 50 MHz core logic. It succeeds the fixed 8N1 receiver by adding parity checking, framing and overrun detection, and a FIFO fill-level output.

## Interface
- `DATA_BITS`, 8: payload bits per frame, legal 5..8.
- `PARITY_MODE`, 0: 0 none, 1 even, 2 odd.
- `STOP_BIT_TICK`, 16: stop length in oversample ticks; 16, 24 or 32 (1, 1.5 or 2 stop bits).
- `BR_LIMIT`, 326: system clocks per oversample tick (50 MHz / (9600·16)).
- `BR_BITS`, 9: baud counter width, ≥ clog2(BR_LIMIT).
- `FIFO_EXP`, 4: FIFO depth = 2^FIFO_EXP words.

Ports:
- `clk_50MHz`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `rx`  in  1  serial line, asynchronous, idle high.
- `read_uart`  in  1  pop head word; ignored when `rx_empty`.
- `clr_overrun`  in  1  one-cycle pulse clearing `overrun`.
- `read_data`  out  DATA_BITS  head-word payload; 0 when empty.
- `read_parity_err`  out  1  head-word parity error; 0 when empty or `PARITY_MODE`=0.
- `read_frame_err`  out  1  head-word framing error; 0 when empty.
- `rx_full`  out  1  FIFO holds 2^FIFO_EXP words.
- `rx_empty`  out  1  FIFO holds 0 words.
- `rx_level`  out  FIFO_EXP+1  current word count.
- `overrun`  out  1  sticky: a completed frame was dropped on full FIFO.

## Operation
- Synchroniser: two flops, reset to 1; FSM sees only synchronised `rx_s`.
- Baud generator: counter 0..BR_LIMIT-1, wraps; `tick` high for one cycle when count = BR_LIMIT-1. Free-running, never restarted by frames.
- FSM states IDLE, START, DATA, PARITY, STOP; counters `s_cnt` (4+ bits, ticks) and `n` (data bits).
  - IDLE: `rx_s`=0 → START, `s_cnt`=0. No tick needed.
  - START: on tick, `s_cnt`=7 → if `rx_s`=0 go DATA with `s_cnt`=0, `n`=0; else glitch, return to IDLE, nothing written. Else `s_cnt`++.
  - DATA: on tick, `s_cnt`=15 → shift `rx_s` into MSB of shift register (right shift, LSB first), `s_cnt`=0; at `n`=DATA_BITS-1 go PARITY if `PARITY_MODE`≠0, else STOP; otherwise `n`++.
  - PARITY: on tick, `s_cnt`=15 → `perr` = (XOR(data) ^ `rx_s`) ≠ (`PARITY_MODE`=2); go STOP, `s_cnt`=0.
  - STOP: on tick, `s_cnt`=15 → `ferr` = ~`rx_s`. At `s_cnt`=STOP_BIT_TICK-1 → IDLE, one-cycle `rx_done`. Framing checks only the first stop bit.
- FIFO entry = {`ferr`, `perr`, data}. On `rx_done`: write if not full, or if full and `read_uart` in the same cycle (pop and push both happen, level unchanged); otherwise drop the word and set `overrun`.
- Read on empty: ignored, no pointer move. Read and write together when empty: the write happens and the read is ignored.
- Pointers are FIFO_EXP bits wide and wrap modulo depth. `rx_level` is updated in the same cycle as the pointers.
- `overrun` set has priority over `clr_overrun` in the same cycle.

## Timing
- Reset values: FSM IDLE, all counters 0, `rx_empty`=1, `rx_full`=0, `rx_level`=0, `overrun`=0, `read_data`=0, both error outputs 0.
- Reset mid-frame: the partial frame is discarded and the FIFO is emptied.
- Head outputs are fall-through: valid combinationally from registered state while `rx_empty`=0.
- After a `read_uart` cycle, the next word is visible the following cycle.
- Latency from `rx_done` to `rx_empty` deasserting: 1 clock.
- Frame latency: `rx_done` occurs about (0.5 + 1 + DATA_BITS + P) bit times after the start edge, plus (STOP_BIT_TICK-16)/16 bit, ±1 tick plus 2 clocks of synchroniser delay. P = 1 when parity is enabled, else 0.

## Test plan
- Defaults, 8N1, 9600 baud: send 0x41, 0x42, 0x43 with 1 ms gaps, no reads → `rx_level`=3, then three pops return 0x41, 0x42, 0x43 with error flags 0; afterwards `rx_empty`=1 and `read_data`=0.
- `PARITY_MODE`=1: send 0x41 with parity bit 0 (correct), then 0x41 with parity bit 1 → `read_parity_err` is 0 then 1. Repeat with `PARITY_MODE`=2 → flags inverted.
- Framing: send 0x55 with stop bit held 0, then line to 1 → `read_frame_err`=1 and `read_data`=0x55.
- Overrun with `FIFO_EXP`=2: send 5 bytes 0x01..0x05 without reading → `rx_full`=1, `overrun`=1, pops return 0x01..0x04; `clr_overrun` → `overrun`=0.
- Glitch and reset: a 2 µs low pulse on `rx` → no write, FSM back to IDLE. Assert `reset` during the data bits of a frame → all outputs at reset values, and no word appears after reset release once the line is idle.
- `DATA_BITS`=7, `STOP_BIT_TICK`=32: send 0x5A with 2 stop bits → `read_data`=0x5A, and `rx_done` falls 2 bit times after the last data bit.
